// File: rtl/ci_media_pkg.sv
// ci_media_pkg
// Shared constants and types for the CI media (transport stream) path:
// the MPEG-TS sync byte, the nominal packet length, the FIFO entry width
// and the transmit FSM state encoding.
package ci_media_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         ENTRY_W      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } txState_e;

  // A FIFO entry is {start flag, data}; it opens a packet only when the
  // host marked it as a start and it carries the TS sync byte.
  function automatic logic isSyncStart(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1] && (entry[7:0] == TS_SYNC_BYTE);
  endfunction

endpackage

// File: rtl/ci_tx_fifo.sv
// ci_tx_fifo
// Single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i          write pushData_i (ignored when full)
//   pushData_i      entry to write
//   pop_i           drop the head entry (ignored when empty)
//   head_o          current head entry, valid whenever empty_o is low
//   full_o, empty_o occupancy flags
//   level_o         number of entries held
module ci_tx_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the separate
  // count register disambiguates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ci_media_tx.sv
// ci_media_tx
// Host-to-CAM transmit half of the CI media interface. Buffers host TS bytes
// and plays out whole packets on MDO/MCLKO/MOVAL/MOSTRT.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_data/in_start   host byte stream (in_start marks byte 0)
//   in_ready                    FIFO can accept a byte
//   tx_enable                   permits starting packets
//   ci_mdo/ci_mclko/ci_moval/ci_mostrt   CAM media output pins
//   fifo_level                  bytes buffered
//   sync_error                  one-clk pulse per dropped byte / truncated packet
//   pkt_count                   completed packets, wrapping 16-bit counter
module ci_media_tx
  import ci_media_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int PKT_LEN    = TS_PKT_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic                        in_start,
  output logic                        in_ready,
  input  logic                        tx_enable,
  output logic [7:0]                  ci_mdo,
  output logic                        ci_mclko,
  output logic                        ci_moval,
  output logic                        ci_mostrt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        sync_error,
  output logic [15:0]                 pkt_count
);

  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(PKT_LEN + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  txState_e           state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [IDX_W-1:0]   byteIdx_q, byteIdx_d;
  logic [7:0]         mdo_q, mdo_d;
  logic               mclko_q, mclko_d;
  logic               moval_q, moval_d;
  logic               mostrt_q, mostrt_d;
  logic               syncErr_q, syncErr_d;
  logic [15:0]        pktCount_q, pktCount_d;

  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] fifoHead;
  logic               headIsStart;
  logic               pktReady;
  logic               phRun;
  logic               slot;
  logic               emit;

  assign in_ready    = !fifoFull && !rst;
  assign fifoPush    = in_valid && in_ready;
  assign headIsStart = !fifoEmpty && isSyncStart(fifoHead);
  assign pktReady    = (fifo_level >= LVL_W'(PKT_LEN));

  ci_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifoPush),
    .pushData_i ({in_start, in_data}),
    .pop_i      (fifoPop),
    .head_o     (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .level_o    (fifo_level)
  );

  // The phase counter only runs while there is something to clock out (or
  // permission to start), so MCLKO parks low when the link is idle. A slot is
  // the wrap edge, which is also where MCLKO falls.
  assign phRun = tx_enable || (state_q != IDLE);
  assign slot  = phRun && (ph_q == PH_W'(CLK_DIV - 1));

  always_comb begin
    ph_d = '0;
    if (phRun && !slot) begin
      ph_d = ph_q + 1'b1;
    end
    mclko_d = (ph_d >= PH_W'(CLK_DIV / 2));
  end

  // Next-state and output logic. Garbage heads are flushed every clk while
  // idle; everything that touches the media pins waits for a slot. The slot
  // that launches a packet already drives byte 0 so the first-byte latency
  // stays within one MCLKO period of the packet becoming complete. The last
  // byte moves to GAP, whose slot drops MOVAL and returns to IDLE, so the
  // next IDLE slot can relaunch after exactly one low period.
  always_comb begin
    state_d    = state_q;
    byteIdx_d  = byteIdx_q;
    mdo_d      = mdo_q;
    moval_d    = moval_q;
    mostrt_d   = mostrt_q;
    syncErr_d  = 1'b0;
    pktCount_d = pktCount_q;
    fifoPop    = 1'b0;
    emit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifoEmpty && !headIsStart) begin
          fifoPop   = 1'b1;
          syncErr_d = 1'b1;
        end else if (slot && tx_enable && headIsStart && pktReady) begin
          emit = 1'b1;
        end
      end
      SEND: begin
        if (slot) begin
          if ((byteIdx_q != '0) && fifoHead[ENTRY_W-1]) begin
            // A new start arrived before this packet was complete: cut it
            // short and leave the new start at the head for the next launch.
            moval_d   = 1'b0;
            mostrt_d  = 1'b0;
            syncErr_d = 1'b1;
            byteIdx_d = '0;
            state_d   = GAP;
          end else begin
            emit = 1'b1;
          end
        end
      end
      GAP: begin
        if (slot) begin
          moval_d  = 1'b0;
          mostrt_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit) begin
      fifoPop  = 1'b1;
      mdo_d    = fifoHead[7:0];
      moval_d  = 1'b1;
      mostrt_d = (byteIdx_q == '0);
      if (byteIdx_q == IDX_W'(PKT_LEN - 1)) begin
        byteIdx_d  = '0;
        pktCount_d = pktCount_q + 16'd1;
        state_d    = GAP;
      end else begin
        byteIdx_d = byteIdx_q + 1'b1;
        state_d   = SEND;
      end
    end
  end

  // All pin-facing outputs are registered so they switch together with the
  // MCLKO falling edge and hold for a whole MCLKO period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      byteIdx_q  <= '0;
      mdo_q      <= '0;
      mclko_q    <= 1'b0;
      moval_q    <= 1'b0;
      mostrt_q   <= 1'b0;
      syncErr_q  <= 1'b0;
      pktCount_q <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      byteIdx_q  <= byteIdx_d;
      mdo_q      <= mdo_d;
      mclko_q    <= mclko_d;
      moval_q    <= moval_d;
      mostrt_q   <= mostrt_d;
      syncErr_q  <= syncErr_d;
      pktCount_q <= pktCount_d;
    end
  end

  assign ci_mdo     = mdo_q;
  assign ci_mclko   = mclko_q;
  assign ci_moval   = moval_q;
  assign ci_mostrt  = mostrt_q;
  assign sync_error = syncErr_q;
  assign pkt_count  = pktCount_q;

endmodule

// File: tb/tb_ci_media_tx.sv
// tb_ci_media_tx
// Directed bench for ci_media_tx with CLK_DIV=4, FIFO_DEPTH=256, PKT_LEN=188.
module tb_ci_media_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 256;
  localparam int PKT_LEN    = 188;
  localparam int PKT_CLKS   = PKT_LEN * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_start = 1'b0;
  logic       tx_enable = 1'b0;
  logic       in_ready;
  logic [7:0] ci_mdo;
  logic       ci_mclko;
  logic       ci_moval;
  logic       ci_mostrt;
  logic [8:0] fifo_level;
  logic       sync_error;
  logic [15:0] pkt_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor state
  logic [7:0] rxData[$];
  bit         rxStart[$];
  int         rises[$];
  int         falls[$];
  int         syncCnt = 0;
  int         mclkRiseLast = 0;
  int         mclkRiseLast2 = 0;
  logic       mclkPrev = 1'b0;
  logic       movalPrev = 1'b0;

  ci_media_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PKT_LEN    (PKT_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_start   (in_start),
    .in_ready   (in_ready),
    .tx_enable  (tx_enable),
    .ci_mdo     (ci_mdo),
    .ci_mclko   (ci_mclko),
    .ci_moval   (ci_moval),
    .ci_mostrt  (ci_mostrt),
    .fifo_level (fifo_level),
    .sync_error (sync_error),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture bytes on MCLKO rising edges (the CAM sampling point), MOVAL
  // edges and sync_error cycles, all sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ci_mclko && !mclkPrev) begin
        mclkRiseLast2 = mclkRiseLast;
        mclkRiseLast  = cyc;
        if (ci_moval) begin
          rxData.push_back(ci_mdo);
          rxStart.push_back(ci_mostrt);
        end
      end
      if (ci_moval && !movalPrev) rises.push_back(cyc);
      if (!ci_moval && movalPrev) falls.push_back(cyc);
      if (sync_error) syncCnt++;
    end
    mclkPrev  = ci_mclko;
    movalPrev = ci_moval;
  end

  function automatic logic [7:0] pktByte(input int kind, input int i);
    if (i == 0) return 8'h47;
    case (kind)
      0:       return 8'(i - 1);
      1:       return 8'(255 - i);
      default: return 8'(i * 3 + 1);
    endcase
  endfunction

  task automatic clearMon;
    rxData.delete();
    rxStart.delete();
    rises.delete();
    falls.delete();
    syncCnt = 0;
  endtask

  task automatic resetDut;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_start = 1'b0;
    tx_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clearMon();
  endtask

  // Push one byte, waiting (bounded) for in_ready.
  task automatic applyStimulus(input logic [7:0] d, input logic s);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout: in_ready=%0d want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_start = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic pushPacket(input int kind, input int n);
    for (int i = 0; i < n; i++) applyStimulus(pktByte(kind, i), (i == 0));
  endtask

  task automatic waitPkts(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (int'(pkt_count) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (int'(pkt_count) < n) begin
      bad++;
      $display("[TB] FAIL %s_wait_pkts: pkt_count=%0d want %0d", tag, pkt_count, n);
    end
  endtask

  task automatic waitRise(input int budget, input string tag);
    int t;
    t = 0;
    while (rises.size() == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (rises.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s_wait_moval: no MOVAL rise within %0d clk", tag, budget);
    end
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %0d want 0", in_ready); end
    total++; if (ci_moval !== 1'b0 || ci_mostrt !== 1'b0 || ci_mclko !== 1'b0) begin bad++; $display("[TB] FAIL reset_pins: moval=%0d mostrt=%0d mclko=%0d want 0", ci_moval, ci_mostrt, ci_mclko); end
    total++; if (ci_mdo !== 8'h00) begin bad++; $display("[TB] FAIL reset_mdo: got %0h want 0", ci_mdo); end
    total++; if (pkt_count !== 16'd0 || fifo_level !== 9'd0 || sync_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_counters: pkt=%0d lvl=%0d serr=%0d want 0", pkt_count, fifo_level, sync_error); end
    rst = 1'b0;
    clearMon();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready: got %0d want 1", in_ready); end
  endtask

  task automatic test_single;
    int lastWr;
    int startCnt;
    $display("[TB] test_single");
    resetDut();
    tx_enable = 1'b1;
    pushPacket(0, PKT_LEN);
    lastWr = cyc;
    waitPkts(1, 1500, "single");
    repeat (20) @(negedge clk);
    total++; if (rises.size() < 1 || rises[0] - lastWr > CLK_DIV + 2 || rises[0] - lastWr < 1) begin bad++; $display("[TB] FAIL single_latency: rises=%0d delta=%0d want 1..%0d", rises.size(), (rises.size() > 0) ? rises[0] - lastWr : -1, CLK_DIV + 2); end
    total++; if (mclkRiseLast - mclkRiseLast2 != CLK_DIV) begin bad++; $display("[TB] FAIL single_mclk_period: got %0d want %0d", mclkRiseLast - mclkRiseLast2, CLK_DIV); end
    total++; if (rises.size() != 1 || falls.size() != 1 || falls[0] - rises[0] != PKT_CLKS) begin bad++; $display("[TB] FAIL single_moval_len: rises=%0d falls=%0d want 1/1 len %0d", rises.size(), falls.size(), PKT_CLKS); end
    total++; if (rxData.size() != PKT_LEN) begin bad++; $display("[TB] FAIL single_byte_count: got %0d want %0d", rxData.size(), PKT_LEN); end
    if (rxData.size() == PKT_LEN) begin
      for (int i = 0; i < PKT_LEN; i++) begin
        total++; if (rxData[i] !== pktByte(0, i)) begin bad++; $display("[TB] FAIL single_mdo[%0d]: got %0h want %0h", i, rxData[i], pktByte(0, i)); end
      end
      startCnt = 0;
      foreach (rxStart[i]) if (rxStart[i]) startCnt++;
      total++; if (startCnt != 1 || rxStart[0] != 1'b1) begin bad++; $display("[TB] FAIL single_mostrt: count=%0d first=%0d want 1/1", startCnt, rxStart[0]); end
    end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("[TB] FAIL single_pkt_count: got %0d want 1", pkt_count); end
    total++; if (syncCnt != 0) begin bad++; $display("[TB] FAIL single_sync_error: got %0d want 0", syncCnt); end
  endtask

  task automatic test_back_to_back;
    $display("[TB] test_back_to_back");
    resetDut();
    tx_enable = 1'b1;
    pushPacket(0, PKT_LEN);
    pushPacket(1, PKT_LEN);
    waitPkts(2, 2500, "b2b");
    repeat (20) @(negedge clk);
    total++; if (rises.size() != 2 || falls.size() != 2) begin bad++; $display("[TB] FAIL b2b_edges: rises=%0d falls=%0d want 2/2", rises.size(), falls.size()); end
    if (rises.size() == 2 && falls.size() == 2) begin
      total++; if (rises[1] - falls[0] != CLK_DIV) begin bad++; $display("[TB] FAIL b2b_gap: got %0d want %0d", rises[1] - falls[0], CLK_DIV); end
      total++; if (falls[1] - rises[1] != PKT_CLKS) begin bad++; $display("[TB] FAIL b2b_len2: got %0d want %0d", falls[1] - rises[1], PKT_CLKS); end
    end
    total++; if (rxData.size() != 2 * PKT_LEN) begin bad++; $display("[TB] FAIL b2b_byte_count: got %0d want %0d", rxData.size(), 2 * PKT_LEN); end
    if (rxData.size() == 2 * PKT_LEN) begin
      for (int i = 0; i < PKT_LEN; i++) begin
        total++; if (rxData[PKT_LEN + i] !== pktByte(1, i)) begin bad++; $display("[TB] FAIL b2b_mdo2[%0d]: got %0h want %0h", i, rxData[PKT_LEN + i], pktByte(1, i)); end
      end
      total++; if (rxStart[PKT_LEN] != 1'b1 || rxStart[PKT_LEN + 1] != 1'b0) begin bad++; $display("[TB] FAIL b2b_mostrt2: got %0d%0d want 10", rxStart[PKT_LEN], rxStart[PKT_LEN + 1]); end
    end
    total++; if (pkt_count !== 16'd2) begin bad++; $display("[TB] FAIL b2b_pkt_count: got %0d want 2", pkt_count); end
  endtask

  task automatic test_garbage;
    logic [7:0] junk [5];
    $display("[TB] test_garbage");
    junk = '{8'h47, 8'h00, 8'h47, 8'hAA, 8'h55};
    resetDut();
    tx_enable = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(junk[i], 1'b0);
    pushPacket(2, PKT_LEN);
    waitPkts(1, 1500, "garbage");
    repeat (20) @(negedge clk);
    total++; if (syncCnt != 5) begin bad++; $display("[TB] FAIL garbage_sync_count: got %0d want 5", syncCnt); end
    total++; if (rxData.size() != PKT_LEN) begin bad++; $display("[TB] FAIL garbage_byte_count: got %0d want %0d", rxData.size(), PKT_LEN); end
    if (rxData.size() == PKT_LEN) begin
      for (int i = 0; i < PKT_LEN; i++) begin
        total++; if (rxData[i] !== pktByte(2, i)) begin bad++; $display("[TB] FAIL garbage_mdo[%0d]: got %0h want %0h", i, rxData[i], pktByte(2, i)); end
      end
    end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("[TB] FAIL garbage_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_short;
    $display("[TB] test_short");
    resetDut();
    tx_enable = 1'b1;
    pushPacket(0, 100);
    pushPacket(1, PKT_LEN);
    waitPkts(1, 3000, "short");
    repeat (20) @(negedge clk);
    total++; if (rises.size() != 2 || falls.size() < 1 || falls[0] - rises[0] != 100 * CLK_DIV) begin bad++; $display("[TB] FAIL short_moval_len: rises=%0d falls=%0d want 2 rises, first len %0d", rises.size(), falls.size(), 100 * CLK_DIV); end
    total++; if (syncCnt != 1) begin bad++; $display("[TB] FAIL short_sync_count: got %0d want 1", syncCnt); end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("[TB] FAIL short_pkt_count: got %0d want 1", pkt_count); end
    total++; if (rxData.size() != 100 + PKT_LEN) begin bad++; $display("[TB] FAIL short_byte_count: got %0d want %0d", rxData.size(), 100 + PKT_LEN); end
    if (rxData.size() == 100 + PKT_LEN) begin
      for (int i = 0; i < 100; i++) begin
        total++; if (rxData[i] !== pktByte(0, i)) begin bad++; $display("[TB] FAIL short_mdoA[%0d]: got %0h want %0h", i, rxData[i], pktByte(0, i)); end
      end
      for (int i = 0; i < PKT_LEN; i++) begin
        total++; if (rxData[100 + i] !== pktByte(1, i)) begin bad++; $display("[TB] FAIL short_mdoB[%0d]: got %0h want %0h", i, rxData[100 + i], pktByte(1, i)); end
      end
    end
  endtask

  task automatic test_disable_mid;
    int highs;
    $display("[TB] test_disable_mid");
    resetDut();
    tx_enable = 1'b1;
    pushPacket(2, PKT_LEN);
    waitRise(100, "disable");
    repeat (50) @(negedge clk);
    tx_enable = 1'b0;
    waitPkts(1, 1500, "disable");
    repeat (10) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ci_mclko !== 1'b0) highs++;
    end
    total++; if (highs != 0) begin bad++; $display("[TB] FAIL disable_mclk_parked: high cycles=%0d want 0", highs); end
    total++; if (rxData.size() != PKT_LEN || falls.size() != 1 || falls[0] - rises[0] != PKT_CLKS) begin bad++; $display("[TB] FAIL disable_complete: bytes=%0d falls=%0d want %0d/1", rxData.size(), falls.size(), PKT_LEN); end
  endtask

  task automatic test_full;
    int j;
    $display("[TB] test_full");
    resetDut();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      @(negedge clk);
      j = (i < PKT_LEN) ? i : i - PKT_LEN;
      in_valid = 1'b1;
      in_data  = pktByte((i < PKT_LEN) ? 0 : 1, j);
      in_start = (j == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_start = 1'b0;
    @(negedge clk);
    total++; if (fifo_level !== 9'd256) begin bad++; $display("[TB] FAIL full_level: got %0d want 256", fifo_level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready: got %0d want 0", in_ready); end
    total++; if (ci_mclko !== 1'b0 || ci_moval !== 1'b0) begin bad++; $display("[TB] FAIL full_idle_pins: mclko=%0d moval=%0d want 0/0", ci_mclko, ci_moval); end
    tx_enable = 1'b1;
    waitPkts(1, 1500, "full");
    repeat (20) @(negedge clk);
    total++; if (fifo_level !== 9'd68) begin bad++; $display("[TB] FAIL full_drain_level: got %0d want 68", fifo_level); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_drain_ready: got %0d want 1", in_ready); end
    total++; if (rises.size() != 1 || rxData.size() != PKT_LEN) begin bad++; $display("[TB] FAIL full_drain_pkts: rises=%0d bytes=%0d want 1/%0d", rises.size(), rxData.size(), PKT_LEN); end
    if (rxData.size() == PKT_LEN) begin
      for (int i = 0; i < PKT_LEN; i++) begin
        total++; if (rxData[i] !== pktByte(0, i)) begin bad++; $display("[TB] FAIL full_mdo[%0d]: got %0h want %0h", i, rxData[i], pktByte(0, i)); end
      end
    end
  endtask

  task automatic test_reset_mid;
    $display("[TB] test_reset_mid");
    resetDut();
    tx_enable = 1'b1;
    pushPacket(2, PKT_LEN);
    waitRise(100, "rstmid");
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ci_moval !== 1'b0 || ci_mostrt !== 1'b0 || ci_mclko !== 1'b0 || ci_mdo !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_pins: moval=%0d mostrt=%0d mclko=%0d mdo=%0h want 0", ci_moval, ci_mostrt, ci_mclko, ci_mdo); end
    total++; if (fifo_level !== 9'd0 || in_ready !== 1'b0 || sync_error !== 1'b0 || pkt_count !== 16'd0) begin bad++; $display("[TB] FAIL rstmid_state: lvl=%0d ready=%0d serr=%0d pkt=%0d want 0", fifo_level, in_ready, sync_error, pkt_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearMon();
    repeat (100) @(negedge clk);
    total++; if (rises.size() != 0) begin bad++; $display("[TB] FAIL rstmid_no_moval: rises=%0d want 0", rises.size()); end
    total++; if (in_ready !== 1'b1 || fifo_level !== 9'd0) begin bad++; $display("[TB] FAIL rstmid_after: ready=%0d lvl=%0d want 1/0", in_ready, fifo_level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_garbage();
    test_short();
    test_disable_mid();
    test_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
